// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel enable and decoded timing outputs of the VGA timing generator.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] row;
  logic [9:0] col;
  logic       hsync;
  logic       vsync;
  logic       blank;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  pix_en,
    output row, col, hsync, vsync, blank, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  row, col, hsync, vsync, blank, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with zero-latency decode of sync, blank and position.
module vga_timing_gen #(
  parameter int H_VIS  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_VIS  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master bus
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
  localparam logic [10:0] H_SYNC_S = 11'(H_VIS + H_FP);
  localparam logic [10:0] H_SYNC_E = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0]  V_SYNC_S = 10'(V_VIS + V_FP);
  localparam logic [9:0]  V_SYNC_E = 10'(V_VIS + V_FP + V_SYNC);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_wrap;
  logic        at_line_start;

  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (bus.pix_en) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  // Pulses are gated by rst_n so they stay low while the counters are held at 0.
  assign at_line_start   = rst_n & bus.pix_en & (h_cnt == 11'd0);
  assign bus.line_start  = at_line_start;
  assign bus.frame_start = at_line_start & (v_cnt == 10'd0);

  assign bus.blank = (h_cnt >= H_VIS_C) || (v_cnt >= V_VIS_C);
  assign bus.col   = (h_cnt < H_VIS_C) ? h_cnt[9:0] : '0;
  assign bus.row   = (v_cnt < V_VIS_C) ? v_cnt : '0;
  assign bus.hsync = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
  assign bus.vsync = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced 20x10 raster.
module tb_vga_timing_gen;
  localparam int HV = 10, HF = 2, HS = 3, HB = 5;
  localparam int VV = 5,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;  // 20
  localparam int VT = VV + VF + VS + VB;  // 10

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int mh = 0, mv = 0;
  bit cur_en = 1'b0;
  int cyc = 0, fs_last = -1, ls_last = -1, fs_gap = 0, ls_gap = 0;
  logic [24:0] sb_q[$];

  function automatic logic [24:0] expect_out(int h, int v, bit en, bit rn);
    logic [9:0] r, c;
    logic hs, vs, bl, ls, fs;
    r  = (v < VV) ? 10'(v) : 10'd0;
    c  = (h < HV) ? 10'(h) : 10'd0;
    hs = (h >= HV + HF) && (h < HV + HF + HS);
    vs = (v >= VV + VF) && (v < VV + VF + VS);
    bl = (h >= HV) || (v >= VV);
    ls = rn && en && (h == 0);
    fs = ls && (v == 0);
    return {r, c, hs, vs, bl, ls, fs};
  endfunction

  task automatic advance();
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: the model sees the edge with the pre-edge inputs, then new inputs are applied.
  task automatic step(bit en, bit rn);
    @(posedge clk);
    if (rst_n && cur_en) advance();
    #1;
    rst_n = rn;
    vif.pix_en = en;
    cur_en = en;
    if (!rn) begin mh = 0; mv = 0; end
    sb_q.push_back(expect_out(mh, mv, en, rn));
  endtask

  task automatic async_reset_mid();
    @(posedge clk);
    if (rst_n && cur_en) advance();
    #3;
    rst_n = 1'b0;
    mh = 0;
    mv = 0;
    #1;
    sb_q.push_back(expect_out(0, 0, cur_en, 1'b0));
  endtask

  always @(negedge clk) begin
    logic [24:0] exp_v, act_v;
    cyc++;
    act_v = {vif.row, vif.col, vif.hsync, vif.vsync, vif.blank, vif.line_start, vif.frame_start};
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d model=(%0d,%0d) actual=%h required=%h", cyc, mh, mv, act_v, exp_v);
      end
    end
    if (vif.frame_start === 1'b1) begin
      if (fs_last >= 0) fs_gap = cyc - fs_last;
      fs_last = cyc;
    end
    if (vif.line_start === 1'b1) begin
      if (ls_last >= 0) ls_gap = cyc - ls_last;
      ls_last = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vif.pix_en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Release and run slightly over two frames at full rate.
    for (int i = 0; i < 450; i++) step(1'b1, 1'b1);
    check("fs_gap_full", fs_gap, 200);
    check("ls_gap_full", ls_gap, 20);

    for (int i = 0; i < 900; i++) step(1'(i % 2), 1'b1);
    check("fs_gap_half", fs_gap, 400);
    check("ls_gap_half", ls_gap, 40);

    for (int i = 0; i < 400 && !(mh == 7 && mv == 3); i++) step(1'b1, 1'b1);
    check("reach_7_3", {mh[15:0], mv[15:0]}, {16'd7, 16'd3});
    async_reset_mid();
    #1;
    check("async_rst_col", vif.col, 0);
    check("async_rst_row", vif.row, 0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    #4;
    check("restart_fs", vif.frame_start, 1);
    check("restart_ls", vif.line_start, 1);

    for (int i = 0; i < 400 && !(mh == 5 && mv == 4); i++) step(1'b1, 1'b1);
    #4;
    check("last_vis_row", vif.row, 4);
    check("last_vis_col", vif.col, 5);
    check("last_vis_blank", vif.blank, 0);

    for (int i = 0; i < 400 && !(mh == 19 && mv == 5); i++) step(1'b1, 1'b1);
    #4;
    check("pre_vsync", vif.vsync, 0);
    check("vblank_row", vif.row, 0);
    step(1'b1, 1'b1);
    #4;
    check("vsync_start", vif.vsync, 1);

    for (int i = 0; i < 400 && !(mh == 19 && mv == 9); i++) step(1'b1, 1'b1);
    #4;
    check("pre_wrap_blank", vif.blank, 1);
    step(1'b1, 1'b1);
    #4;
    check("wrap_fs", vif.frame_start, 1);
    check("wrap_vsync", vif.vsync, 0);
    check("wrap_blank", vif.blank, 0);

    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
